// File: rtl/noc_flit_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : noc_flit_deserializer
// Purpose  : Receive-side NoC adapter. Collects a header flit plus its payload
//            flits from a valid/ready flit stream and presents them as one
//            complete response message to the cache return-packet decoder.
// Ports    : clk_i, rst_i            - clock, synchronous active-high reset
//            flit_i/flit_valid_i/flit_ready_o - incoming flit stream
//            msg_valid_o/msg_ready_i          - assembled message handshake
//            msg_header_o, msg_payload_o      - captured header and payload
//            msg_len_o                        - stored payload flit count
//            msg_type_o, msg_mshrid_o         - header fields
//            err_len_o                        - oversize header pulse
// Config   : CVA6_NOC_DESER_LEN_CHECK_EN - when defined, headers announcing
//            more than MaxPayloadFlits payload flits pulse err_len_o and the
//            whole message is consumed and dropped. When undefined, oversize
//            messages are truncated to MaxPayloadFlits stored flits.
// Revision : 1.0 - initial release
// ============================================================================
module noc_flit_deserializer #(
   parameter int unsigned FlitWidth       = 64,
   parameter int unsigned MaxPayloadFlits = 8,
   parameter int unsigned CntWidth        = 8
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [FlitWidth-1:0]                 flit_i,
   input  logic                                 flit_valid_i,
   output logic                                 flit_ready_o,
   output logic                                 msg_valid_o,
   input  logic                                 msg_ready_i,
   output logic [FlitWidth-1:0]                 msg_header_o,
   output logic [MaxPayloadFlits*FlitWidth-1:0] msg_payload_o,
   output logic [$clog2(MaxPayloadFlits+1)-1:0] msg_len_o,
   output logic [7:0]                           msg_type_o,
   output logic [7:0]                           msg_mshrid_o,
   output logic                                 err_len_o
);

   localparam int unsigned          LenWidth  = $clog2(MaxPayloadFlits + 1);
   localparam logic [CntWidth-1:0]  MaxFlitsC = CntWidth'(MaxPayloadFlits);

`ifdef CVA6_NOC_DESER_LEN_CHECK_EN
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      OUTPUT  = 2'd2,
      DROP    = 2'd3
   } state_e;
`else
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      OUTPUT  = 2'd2
   } state_e;
`endif

   state_e                                        state_q,   state_d;
   logic [FlitWidth-1:0]                          header_q,  header_d;
   logic [CntWidth-1:0]                           len_q,     len_d;
   logic [CntWidth-1:0]                           cnt_q,     cnt_d;
   logic [MaxPayloadFlits-1:0][FlitWidth-1:0]     payload_q, payload_d;

   logic                  ready;
   logic                  valid;
   logic [CntWidth-1:0]   hdr_len;
   logic                  last_flit;

   // Length field of the flit currently on the input (only meaningful in IDLE).
   assign hdr_len   = flit_i[22 +: CntWidth];
   // cnt only ever reaches len-1, so this never needs a wrap guard.
   assign last_flit = (cnt_q == (len_q - 1'b1));

`ifdef CVA6_NOC_DESER_LEN_CHECK_EN
   logic err_q, err_d;
`endif

   always_comb begin
      state_d   = state_q;
      header_d  = header_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      payload_d = payload_q;
      ready     = 1'b0;
      valid     = 1'b0;
`ifdef CVA6_NOC_DESER_LEN_CHECK_EN
      err_d     = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (flit_valid_i) begin
               len_d     = hdr_len;
               cnt_d     = '0;
               header_d  = flit_i;
               payload_d = '0;
               state_d   = (hdr_len == '0) ? OUTPUT : PAYLOAD;
`ifdef CVA6_NOC_DESER_LEN_CHECK_EN
               if (hdr_len > MaxFlitsC) begin
                  // Oversize message is discarded: keep the previous message
                  // registers untouched and only track the flit count.
                  header_d  = header_q;
                  payload_d = payload_q;
                  err_d     = 1'b1;
                  state_d   = DROP;
               end
`endif
            end
         end

         PAYLOAD: begin
            ready = 1'b1;
            if (flit_valid_i) begin
               // Flits beyond the storage depth match no slot and are dropped.
               for (int unsigned k = 0; k < MaxPayloadFlits; k++) begin
                  if (cnt_q == CntWidth'(k)) begin
                     payload_d[k] = flit_i;
                  end
               end
               if (last_flit) begin
                  state_d = OUTPUT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         OUTPUT: begin
            valid = 1'b1;
            if (msg_ready_i) begin
               state_d = IDLE;
            end
         end

`ifdef CVA6_NOC_DESER_LEN_CHECK_EN
         DROP: begin
            ready = 1'b1;
            if (flit_valid_i) begin
               if (last_flit) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
`endif

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         header_q  <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         payload_q <= '0;
      end else begin
         state_q   <= state_d;
         header_q  <= header_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         payload_q <= payload_d;
      end
   end

`ifdef CVA6_NOC_DESER_LEN_CHECK_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
   assign err_len_o = err_q;
`else
   assign err_len_o = 1'b0;
`endif

   // Ready is forced low while reset is held so no flit is lost to a reset.
   assign flit_ready_o  = ready & ~rst_i;
   assign msg_valid_o   = valid;
   assign msg_header_o  = header_q;
   assign msg_payload_o = payload_q;
   assign msg_type_o    = header_q[21:14];
   assign msg_mshrid_o  = header_q[13:6];
   assign msg_len_o     = (len_q > MaxFlitsC) ? LenWidth'(MaxPayloadFlits)
                                              : len_q[LenWidth-1:0];

endmodule
`default_nettype wire
